// File: rtl/capture_sequencer_pkg.sv
// Shared definitions for the capture sequencer and the MCU status register decoder.
package capture_sequencer_pkg;

  localparam int unsigned ADDR_W_DEF = 18;
  localparam int unsigned TMO_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRETRIG   = 3'd1,
    ST_ARMED     = 3'd2,
    ST_TRIGGERED = 3'd3,
    ST_READOUT   = 3'd4
  } cap_state_e;

  function automatic logic is_busy(input cap_state_e s);
    return (s == ST_PRETRIG) || (s == ST_ARMED) || (s == ST_TRIGGERED);
  endfunction

endpackage

// File: rtl/capture_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and a terminal-value compare.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         hit
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit = (count_q == limit);

endmodule

// File: rtl/capture_sequencer.sv
// Acquisition controller: pre-trigger fill, arming with auto/forced trigger, then SRAM readout.
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned TMO_W  = TMO_W_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              CLK_EN,
  input  logic              CMD_START,
  input  logic              CMD_STOP,
  input  logic              CMD_FORCE,
  input  logic              AUTO_MODE,
  input  logic [ADDR_W-1:0] PRETRIG_LEN,
  input  logic [TMO_W-1:0]  AUTO_TMO,
  input  logic              WRITE_READY,
  input  logic [ADDR_W-1:0] ADDR_CNT_IN,
  input  logic              RD_REQ,
  output logic              START_WRITE,
  output logic              ENABLE_TRIG,
  output logic              FORCE_TRIG,
  output logic              SRAM_OWNER,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic              RD_STROBE,
  output logic              BUSY,
  output logic              DONE,
  output logic [2:0]        STATE
);

  cap_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              force_trig_q, force_trig_d;
  logic              rd_strobe_q, rd_strobe_d;
  logic              start_write_q, start_write_d;
  logic              enable_trig_q, enable_trig_d;
  logic              sram_owner_q, sram_owner_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pre_hit, tmo_hit, auto_fire;

  // Counters sit at zero whenever their state is inactive, so entry always starts from 0.
  sat_counter #(.W(ADDR_W)) u_pre_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .clr   (state_q != ST_PRETRIG),
    .en    (CLK_EN),
    .limit (PRETRIG_LEN),
    .hit   (pre_hit)
  );

  sat_counter #(.W(TMO_W)) u_tmo_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .clr   (state_q != ST_ARMED),
    .en    (CLK_EN),
    .limit (AUTO_TMO),
    .hit   (tmo_hit)
  );

  assign auto_fire = AUTO_MODE && tmo_hit && (AUTO_TMO != '0);

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    force_trig_d = 1'b0;
    rd_strobe_d  = 1'b0;
    if (CMD_STOP) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (CMD_START) state_d = ST_PRETRIG;
        end
        ST_PRETRIG: begin
          if (pre_hit) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (CMD_FORCE || auto_fire) begin
            state_d      = ST_TRIGGERED;
            force_trig_d = 1'b1;
          end else if (WRITE_READY) begin
            state_d = ST_TRIGGERED;
          end
        end
        ST_TRIGGERED: begin
          if (WRITE_READY) begin
            state_d   = ST_READOUT;
            rd_addr_d = ADDR_CNT_IN;
          end
        end
        ST_READOUT: begin
          if (CMD_START) begin
            state_d = ST_PRETRIG;
          end else if (RD_REQ) begin
            rd_strobe_d = 1'b1;
            rd_addr_d   = rd_addr_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Level outputs are decoded from the next state so they line up with STATE.
    start_write_d = is_busy(state_d);
    busy_d        = is_busy(state_d);
    enable_trig_d = (state_d == ST_ARMED) || (state_d == ST_TRIGGERED);
    sram_owner_d  = (state_d == ST_READOUT);
    done_d        = (state_d == ST_READOUT);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= ST_IDLE;
      rd_addr_q     <= '0;
      force_trig_q  <= 1'b0;
      rd_strobe_q   <= 1'b0;
      start_write_q <= 1'b0;
      enable_trig_q <= 1'b0;
      sram_owner_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      force_trig_q  <= force_trig_d;
      rd_strobe_q   <= rd_strobe_d;
      start_write_q <= start_write_d;
      enable_trig_q <= enable_trig_d;
      sram_owner_q  <= sram_owner_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign STATE       = state_q;
  assign RD_ADDR     = rd_addr_q;
  assign FORCE_TRIG  = force_trig_q;
  assign RD_STROBE   = rd_strobe_q;
  assign START_WRITE = start_write_q;
  assign ENABLE_TRIG = enable_trig_q;
  assign SRAM_OWNER  = sram_owner_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed scenarios plus randomized traffic checked against a cycle-level behavioural model.
module tb_capture_sequencer;

  localparam int AW      = 18;
  localparam int TW      = 16;
  localparam int PRE_MAX = (1 << AW) - 1;
  localparam int TMO_MAX = (1 << TW) - 1;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          CLK_EN = 1'b0;
  logic          CMD_START = 1'b0;
  logic          CMD_STOP = 1'b0;
  logic          CMD_FORCE = 1'b0;
  logic          AUTO_MODE = 1'b0;
  logic [AW-1:0] PRETRIG_LEN = '0;
  logic [TW-1:0] AUTO_TMO = '0;
  logic          WRITE_READY = 1'b0;
  logic [AW-1:0] ADDR_CNT_IN = '0;
  logic          RD_REQ = 1'b0;
  logic          START_WRITE, ENABLE_TRIG, FORCE_TRIG, SRAM_OWNER, RD_STROBE, BUSY, DONE;
  logic [AW-1:0] RD_ADDR;
  logic [2:0]    STATE;

  capture_sequencer #(.ADDR_W(AW), .TMO_W(TW)) dut (
    .CLK(CLK), .nRST(nRST), .CLK_EN(CLK_EN), .CMD_START(CMD_START), .CMD_STOP(CMD_STOP),
    .CMD_FORCE(CMD_FORCE), .AUTO_MODE(AUTO_MODE), .PRETRIG_LEN(PRETRIG_LEN), .AUTO_TMO(AUTO_TMO),
    .WRITE_READY(WRITE_READY), .ADDR_CNT_IN(ADDR_CNT_IN), .RD_REQ(RD_REQ),
    .START_WRITE(START_WRITE), .ENABLE_TRIG(ENABLE_TRIG), .FORCE_TRIG(FORCE_TRIG),
    .SRAM_OWNER(SRAM_OWNER), .RD_ADDR(RD_ADDR), .RD_STROBE(RD_STROBE), .BUSY(BUSY),
    .DONE(DONE), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: phase number (0..4), ticks spent in the fill / armed phases, readout pointer.
  int m_st, m_pre, m_tmo, m_rdaddr;
  bit m_ft, m_rs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    m_st = 0; m_pre = 0; m_tmo = 0; m_rdaddr = 0; m_ft = 0; m_rs = 0;
  endfunction

  function automatic void model_step();
    int nst;
    nst  = m_st;
    m_ft = 0;
    m_rs = 0;
    if (CMD_STOP) nst = 0;
    else begin
      case (m_st)
        0: if (CMD_START) nst = 1;
        1: if (m_pre == int'(PRETRIG_LEN)) nst = 2;
        2: begin
          if (CMD_FORCE) begin nst = 3; m_ft = 1; end
          else if (AUTO_MODE && AUTO_TMO != 0 && m_tmo == int'(AUTO_TMO)) begin nst = 3; m_ft = 1; end
          else if (WRITE_READY) nst = 3;
        end
        3: if (WRITE_READY) begin nst = 4; m_rdaddr = int'(ADDR_CNT_IN); end
        4: begin
          if (CMD_START) nst = 1;
          else if (RD_REQ) begin m_rs = 1; m_rdaddr = (m_rdaddr + 1) % (1 << AW); end
        end
        default: nst = 0;
      endcase
    end
    if (m_st == 1) m_pre = (CLK_EN && m_pre < PRE_MAX) ? m_pre + 1 : m_pre;
    else m_pre = 0;
    if (m_st == 2) m_tmo = (CLK_EN && m_tmo < TMO_MAX) ? m_tmo + 1 : m_tmo;
    else m_tmo = 0;
    m_st = nst;
  endfunction

  task automatic compare_all();
    bit busy_e;
    busy_e = (m_st >= 1 && m_st <= 3);
    check_eq("STATE",       32'(STATE),       32'(m_st));
    check_eq("START_WRITE", 32'(START_WRITE), 32'(busy_e));
    check_eq("BUSY",        32'(BUSY),        32'(busy_e));
    check_eq("ENABLE_TRIG", 32'(ENABLE_TRIG), 32'(m_st == 2 || m_st == 3));
    check_eq("SRAM_OWNER",  32'(SRAM_OWNER),  32'(m_st == 4));
    check_eq("DONE",        32'(DONE),        32'(m_st == 4));
    check_eq("FORCE_TRIG",  32'(FORCE_TRIG),  32'(m_ft));
    check_eq("RD_STROBE",   32'(RD_STROBE),   32'(m_rs));
    check_eq("RD_ADDR",     32'(RD_ADDR),     32'(m_rdaddr));
  endtask

  // One clock: model and DUT both consume the current inputs, then pulses drop.
  task automatic tick();
    @(posedge CLK);
    if (nRST) model_step();
    else model_reset();
    #1;
    compare_all();
    CMD_START = 0; CMD_STOP = 0; CMD_FORCE = 0; WRITE_READY = 0; RD_REQ = 0;
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    check_eq("rst_state", 32'(STATE), 32'd0);
    nRST = 1;
    tick();

    // Pre-trigger fill with CLK_EN every second cycle.
    PRETRIG_LEN = AW'(5);
    CLK_EN = 1;
    CMD_START = 1;
    tick();
    check_eq("sw_rise", 32'(START_WRITE), 32'd1);
    for (int i = 0; i < 9; i++) begin
      CLK_EN = (i % 2 == 0);
      tick();
    end
    check_eq("pre_not_armed", 32'(ENABLE_TRIG), 32'd0);
    CLK_EN = 0;
    tick();
    check_eq("pre_armed", 32'(ENABLE_TRIG), 32'd1);
    check_eq("pre_state2", 32'(STATE), 32'd2);

    CMD_START = 1;
    tick();
    check_eq("start_ignored", 32'(STATE), 32'd2);

    // Asynchronous reset in the middle of ARMED.
    #2 nRST = 0;
    #1;
    model_reset();
    compare_all();
    check_eq("rst_async_state", 32'(STATE), 32'd0);
    tick();
    nRST = 1;
    tick();

    // Auto trigger after three ticks, then latch of the write pointer.
    AUTO_MODE = 1; AUTO_TMO = TW'(3); PRETRIG_LEN = '0; CLK_EN = 1;
    CMD_START = 1;
    tick();
    tick();
    check_eq("auto_armed", 32'(STATE), 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("auto_early", 32'(FORCE_TRIG), 32'd0);
    end
    tick();
    check_eq("auto_fire", 32'(FORCE_TRIG), 32'd1);
    tick();
    check_eq("auto_pulse_end", 32'(FORCE_TRIG), 32'd0);
    ADDR_CNT_IN = AW'(32'h1FFFE);
    WRITE_READY = 1;
    tick();
    check_eq("ro_state", 32'(STATE), 32'd4);
    check_eq("ro_owner", 32'(SRAM_OWNER), 32'd1);
    check_eq("ro_addr", 32'(RD_ADDR), 32'h1FFFE);

    // Start beats WRITE_READY in readout; stop beats force in armed.
    CMD_START = 1; WRITE_READY = 1;
    tick();
    check_eq("restart_state", 32'(STATE), 32'd1);
    check_eq("restart_owner", 32'(SRAM_OWNER), 32'd0);
    tick();
    CMD_STOP = 1; CMD_FORCE = 1;
    tick();
    check_eq("stop_state", 32'(STATE), 32'd0);
    check_eq("stop_noforce", 32'(FORCE_TRIG), 32'd0);

    // Readout address wrap.
    CMD_START = 1;
    tick();
    tick();
    CMD_FORCE = 1;
    tick();
    check_eq("force_pulse", 32'(FORCE_TRIG), 32'd1);
    ADDR_CNT_IN = AW'(32'h3FFFE);
    WRITE_READY = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp_addr;
      exp_addr = (32'h3FFFF + 32'(i)) & 32'h3FFFF;
      RD_REQ = 1;
      tick();
      check_eq("wrap_strobe", 32'(RD_STROBE), 32'd1);
      check_eq("wrap_addr", 32'(RD_ADDR), exp_addr);
      tick();
      check_eq("wrap_strobe_end", 32'(RD_STROBE), 32'd0);
    end

    CMD_STOP = 1;
    tick();
    RD_REQ = 1;
    tick();
    check_eq("idle_rdreq_strobe", 32'(RD_STROBE), 32'd0);
    check_eq("idle_rdreq_addr", 32'(RD_ADDR), 32'h1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        PRETRIG_LEN = AW'($urandom_range(0, 6));
        AUTO_TMO    = TW'($urandom_range(0, 5));
        AUTO_MODE   = 1'($urandom_range(0, 1));
      end
      CLK_EN      = 1'($urandom_range(0, 1));
      CMD_START   = ($urandom % 100) < 6;
      CMD_STOP    = ($urandom % 100) < 2;
      CMD_FORCE   = ($urandom % 100) < 4;
      WRITE_READY = ($urandom % 100) < 8;
      RD_REQ      = ($urandom % 100) < 35;
      ADDR_CNT_IN = AW'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
